// File: rtl/l1_inval_unit_if.sv
// Request and tag-RAM port bundle for l1_inval_unit.
// The master modport is the invalidation unit; the slave modport is the requester/tag-RAM side.
interface l1_inval_unit_if #(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned NumSets     = 256,
   parameter int unsigned NumWays     = 2
);
   localparam int unsigned OffW = $clog2(L1LineWidth);
   localparam int unsigned IdxW = $clog2(NumSets);
   localparam int unsigned TagW = AddrWidth - IdxW - OffW;

   // Handshakes: a request moves when inval_valid_i && inval_ready_o at a rising edge;
   // a tag access completes when tag_req_o && tag_gnt_i at a rising edge, and the
   // requester holds every tag_* output stable until then.
   logic [AddrWidth-1:0]          inval_addr_i;
   logic                          inval_valid_i;
   logic                          inval_ready_o;
   logic                          tag_req_o;
   logic                          tag_gnt_i;
   logic                          tag_we_o;
   logic [IdxW-1:0]               tag_idx_o;
   logic [NumWays-1:0]            tag_wmask_o;
   logic [NumWays*(TagW+1)-1:0]   tag_rdata_i;
   logic [31:0]                   inval_cnt_o;
   logic [31:0]                   hit_cnt_o;

   modport master (
      input  inval_addr_i, inval_valid_i, tag_gnt_i, tag_rdata_i,
      output inval_ready_o, tag_req_o, tag_we_o, tag_idx_o, tag_wmask_o,
             inval_cnt_o, hit_cnt_o
   );

   modport slave (
      output inval_addr_i, inval_valid_i, tag_gnt_i, tag_rdata_i,
      input  inval_ready_o, tag_req_o, tag_we_o, tag_idx_o, tag_wmask_o,
             inval_cnt_o, hit_cnt_o
   );
endinterface

// File: rtl/l1_inval_unit.sv
// L1 line invalidation: read the set, compare all ways, clear every matching way in one write.
// Optional statistics counters are built when L1_INVAL_STATS_EN is defined.
module l1_inval_unit #(
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned L1LineWidth = 16,
   parameter int unsigned NumSets     = 256,
   parameter int unsigned NumWays     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   l1_inval_unit_if.master      bus,
   output logic [1:0]           dbg_state
);
   localparam int unsigned OffW = $clog2(L1LineWidth);
   localparam int unsigned IdxW = $clog2(NumSets);
   localparam int unsigned TagW = AddrWidth - IdxW - OffW;

   typedef enum logic [1:0] {
      Idle    = 2'd0,
      Read    = 2'd1,
      Compare = 2'd2,
      Clear   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IdxW-1:0]    idx_q;
   logic [TagW-1:0]    tag_q;
   logic [NumWays-1:0] hit_q, hit_d;
   logic               handshake;
   logic               unused_offset;

   assign handshake     = bus.inval_valid_i && (state_q == Idle);
   assign unused_offset = ^bus.inval_addr_i[OffW-1:0];
   assign dbg_state     = state_q;
   assign bus.tag_idx_o = idx_q;

   // Read data is only meaningful in Compare, one cycle after the granted read.
   always_comb begin
      hit_d = '0;
      for (int w = 0; w < NumWays; w++) begin
         hit_d[w] = bus.tag_rdata_i[w*(TagW+1) + TagW] &&
                    (bus.tag_rdata_i[w*(TagW+1) +: TagW] == tag_q);
      end
   end

   always_comb begin
      state_d           = state_q;
      bus.inval_ready_o = 1'b0;
      bus.tag_req_o     = 1'b0;
      bus.tag_we_o      = 1'b0;
      bus.tag_wmask_o   = '0;
      case (state_q)
         Idle: begin
            bus.inval_ready_o = 1'b1;
            if (bus.inval_valid_i) state_d = Read;
         end
         Read: begin
            bus.tag_req_o = 1'b1;
            if (bus.tag_gnt_i) state_d = Compare;
         end
         Compare: begin
            state_d = (|hit_d) ? Clear : Idle;
         end
         Clear: begin
            bus.tag_req_o   = 1'b1;
            bus.tag_we_o    = 1'b1;
            bus.tag_wmask_o = hit_q;
            if (bus.tag_gnt_i) state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         idx_q   <= '0;
         tag_q   <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            idx_q <= bus.inval_addr_i[OffW +: IdxW];
            tag_q <= bus.inval_addr_i[AddrWidth-1 -: TagW];
         end
         if (state_q == Compare) hit_q <= hit_d;
      end
   end

`ifdef L1_INVAL_STATS_EN
   logic [31:0] inval_cnt_q, hit_cnt_q;

   // Both counters wrap naturally at 32 bits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inval_cnt_q <= '0;
         hit_cnt_q   <= '0;
      end else begin
         if (handshake) inval_cnt_q <= inval_cnt_q + 32'd1;
         if ((state_q == Clear) && bus.tag_gnt_i) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
   end

   assign bus.inval_cnt_o = inval_cnt_q;
   assign bus.hit_cnt_o   = hit_cnt_q;
`else
   assign bus.inval_cnt_o = '0;
   assign bus.hit_cnt_o   = '0;
`endif
endmodule
